// File: rtl/dstack_spill_control_if.sv
// Single-outstanding memory port used to spill and refill the data stack.
// The controller drives the request side; the memory answers with ack/rdata.
interface dstack_spill_control_if #(
  parameter int unsigned WORD_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dstack_spill_control.sv
// Tracks on-chip data-stack depth, spills the bottom entry when high, refills it
// when low, and stalls the core when a stack movement cannot be honoured yet.
module dstack_spill_control #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           SPILL_HIGH = 12,
  parameter int unsigned           FILL_LOW   = 4,
  parameter logic [WORD_WIDTH-1:0] STACK_BASE = '0,
  localparam int unsigned          CW         = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               movement,
  input  logic                     move_valid,
  output logic                     stall,
  output logic                     underflow,
  output logic [CW-1:0]            count,
  output logic                     bottom_pop,
  output logic                     bottom_push,
  output logic [WORD_WIDTH-1:0]    fill_data,
  input  logic [WORD_WIDTH-1:0]    bottom_data,
  dstack_spill_control_if.master   mem
);

  typedef enum logic [1:0] {StIdle, StSpill, StFill} state_e;

  state_e                state_q;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_WIDTH-1:0] spill_ptr_q;
  logic                  underflow_q;
  logic                  mem_req_q, mem_we_q;
  logic [WORD_WIDTH-1:0] mem_addr_q;

  logic          spilled_any, grow, short_hit, full, applied, uf_hit;
  logic [1:0]    need;
  logic [CW-1:0] pops;

  assign spilled_any = (spill_ptr_q != STACK_BASE);

  always_comb begin
    need = 2'd0;
    grow = 1'b0;
    unique case (movement)
      2'b01:   grow = 1'b1;
      2'b10:   need = 2'd1;
      2'b11:   need = 2'd2;
      default: ;
    endcase
  end

  assign short_hit = ({{(CW-2){1'b0}}, need} > count_q);
  assign full      = (count_q == CW'(DEPTH));
  assign stall     = move_valid & ((full & grow) | (short_hit & spilled_any));
  assign uf_hit    = move_valid & short_hit & ~spilled_any;
  assign applied   = move_valid & ~stall;
  // An underflowing pop only removes what is actually on chip.
  assign pops      = short_hit ? count_q : CW'(need);

  assign bottom_pop  = (state_q == StSpill) & mem.mem_ack & ~reset;
  assign bottom_push = (state_q == StFill) & mem.mem_ack & ~reset;

  always_comb begin
    count_d = count_q;
    if (applied) count_d = count_d + CW'(grow) - pops;
    count_d = count_d - CW'(bottom_pop) + CW'(bottom_push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      spill_ptr_q <= STACK_BASE;
      underflow_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (uf_hit) underflow_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (count_q >= CW'(SPILL_HIGH)) begin
            state_q    <= StSpill;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= spill_ptr_q;
          end else if ((count_q <= CW'(FILL_LOW)) && spilled_any) begin
            state_q    <= StFill;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= spill_ptr_q - WORD_WIDTH'(1);
          end
        end
        StSpill: begin
          if (mem.mem_ack) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            spill_ptr_q <= spill_ptr_q + WORD_WIDTH'(1);
          end
        end
        StFill: begin
          if (mem.mem_ack) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            spill_ptr_q <= spill_ptr_q - WORD_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign count         = count_q;
  assign underflow     = underflow_q;
  assign fill_data     = mem.mem_rdata;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  // The register file holds its bottom entry stable while a spill is pending.
  assign mem.mem_wdata = (state_q == StSpill) ? bottom_data : '0;

endmodule

// File: tb/tb_dstack_spill_control.sv
// Bench for dstack_spill_control: directed vector table, hand corner sequences, and
// random traffic against a queue-based model of the on-chip stack and spill memory.
module tb_dstack_spill_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  movement = 2'b00;
  logic        move_valid = 1'b0;
  logic        stall, underflow, bottom_pop, bottom_push;
  logic [4:0]  count;
  logic [31:0] fill_data;
  logic [31:0] bottom_data = 32'hCAFE_0001;

  int vecs = 0;
  int errs = 0;

  dstack_spill_control_if #(.WORD_WIDTH(32)) mem_if ();

  dstack_spill_control dut (
    .clk        (clk),
    .reset      (reset),
    .movement   (movement),
    .move_valid (move_valid),
    .stall      (stall),
    .underflow  (underflow),
    .count      (count),
    .bottom_pop (bottom_pop),
    .bottom_push(bottom_push),
    .fill_data  (fill_data),
    .bottom_data(bottom_data),
    .mem        (mem_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are settled 1 time unit later.
  task automatic cyc(input logic r, input logic mv, input logic [1:0] mov, input logic ack);
    @(negedge clk);
    reset          = r;
    move_valid     = mv;
    movement       = mov;
    mem_if.mem_ack = ack;
    #1;
  endtask

  task automatic rst2();
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  typedef struct {
    logic        mv;
    logic [1:0]  mov;
    logic        ack;
    int          cnt;
    logic        stl;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        pop;
    logic        push;
    logic        uf;
  } vec_t;

  function automatic vec_t v(logic mv, logic [1:0] mov, logic ack, int cnt, logic stl,
                             logic req, logic we, logic [31:0] addr, logic pop,
                             logic push, logic uf);
    vec_t t;
    t.mv = mv; t.mov = mov; t.ack = ack; t.cnt = cnt; t.stl = stl; t.req = req;
    t.we = we; t.addr = addr; t.pop = pop; t.push = push; t.uf = uf;
    return t;
  endfunction

  // Random-phase model state: on-chip stack (index 0 = bottom) and spill memory.
  logic [31:0] onchip[$];
  logic [31:0] memw[logic [31:0]];
  logic [31:0] m_ptr;
  int          m_txn;  // 0 none, 1 spill outstanding, 2 fill outstanding
  logic        m_uf;
  int          m_wait;

  task automatic model_clear();
    onchip.delete();
    memw.delete();
    m_ptr  = 32'd0;
    m_txn  = 0;
    m_uf   = 1'b0;
    m_wait = 0;
  endtask

  task automatic rand_cycle(input int p_push);
    int          r, need, c0, npop;
    logic        grow, mv, ack, e_stall, e_pop, e_push, e_req, applied;
    logic [1:0]  mov;
    logic [31:0] front;
    r   = int'($urandom_range(0, 99));
    mov = (r < p_push) ? 2'b01 : (r < p_push + 15) ? 2'b00 :
          (r < p_push + 15 + (85 - p_push) / 2) ? 2'b10 : 2'b11;
    mv    = ($urandom_range(0, 99) < 85);
    e_req = (m_txn != 0);
    if (e_req) ack = (m_wait >= 3) || ($urandom_range(0, 2) == 0);
    else       ack = ($urandom_range(0, 3) == 0);
    @(negedge clk);
    reset          = 1'b0;
    move_valid     = mv;
    movement       = mov;
    mem_if.mem_ack = ack;
    bottom_data    = (onchip.size() > 0) ? onchip[0] : 32'h0;
    mem_if.mem_rdata = (m_txn == 2 && memw.exists(m_ptr - 1)) ? memw[m_ptr - 1] : $urandom;
    #1;
    c0   = onchip.size();
    grow = (mov == 2'b01);
    need = (mov == 2'b10) ? 1 : (mov == 2'b11) ? 2 : 0;
    e_stall = mv && ((c0 == 16 && grow) || (c0 < need && m_ptr != 0));
    e_pop   = (m_txn == 1) && ack;
    e_push  = (m_txn == 2) && ack;
    chk("rnd count", 32'(count), 32'(c0));
    chk("rnd stall", 32'(stall), 32'(e_stall));
    chk("rnd mem_req", 32'(mem_if.mem_req), 32'(e_req));
    chk("rnd bottom_pop", 32'(bottom_pop), 32'(e_pop));
    chk("rnd bottom_push", 32'(bottom_push), 32'(e_push));
    chk("rnd underflow", 32'(underflow), 32'(m_uf));
    if (e_req) begin
      chk("rnd mem_we", 32'(mem_if.mem_we), 32'(m_txn == 1));
      chk("rnd mem_addr", mem_if.mem_addr, (m_txn == 1) ? m_ptr : m_ptr - 1);
      if (m_txn == 1) chk("rnd mem_wdata", mem_if.mem_wdata, onchip[0]);
    end
    front = (c0 > 0) ? onchip[0] : 32'h0;
    if (mv && c0 < need && m_ptr == 0) m_uf = 1'b1;
    applied = mv && !e_stall;
    if (applied) begin
      npop = (c0 < need) ? c0 : need;
      repeat (npop) void'(onchip.pop_back());
      if (grow) onchip.push_back($urandom);
    end
    if (e_pop) begin
      memw[m_ptr] = front;
      void'(onchip.pop_front());
      m_ptr++;
    end
    if (e_push) begin
      onchip.push_front(memw[m_ptr - 1]);
      m_ptr--;
    end
    if (e_req && !ack) m_wait++;
    else m_wait = 0;
    if (m_txn != 0) begin
      if (ack) m_txn = 0;
    end else if (c0 >= 12) m_txn = 1;
    else if (c0 <= 4 && m_ptr != 0) m_txn = 2;
  endtask

  vec_t tbl[$];

  initial begin
    // Spill twice, drain to low, fill twice (one stalled pop-two), then underflow.
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) tbl.push_back(v(1, 2'b01, 0, i, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 12, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 2'b00, 0, 12, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b01, 1, 12, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 12, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 1, 12, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 11, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 11, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 11, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 9, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b10, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 4, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 1, 4, 0, 1, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, 2'b00, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 3, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 3, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 1, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 2'b10, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    mem_if.mem_rdata = 32'h5EED_0042;
    rst2();
    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].mv, tbl[i].mov, tbl[i].ack);
      chk($sformatf("tbl[%0d] count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d] stall", i), 32'(stall), 32'(tbl[i].stl));
      chk($sformatf("tbl[%0d] mem_req", i), 32'(mem_if.mem_req), 32'(tbl[i].req));
      chk($sformatf("tbl[%0d] bottom_pop", i), 32'(bottom_pop), 32'(tbl[i].pop));
      chk($sformatf("tbl[%0d] bottom_push", i), 32'(bottom_push), 32'(tbl[i].push));
      chk($sformatf("tbl[%0d] underflow", i), 32'(underflow), 32'(tbl[i].uf));
      if (tbl[i].req) begin
        chk($sformatf("tbl[%0d] mem_we", i), 32'(mem_if.mem_we), 32'(tbl[i].we));
        chk($sformatf("tbl[%0d] mem_addr", i), mem_if.mem_addr, tbl[i].addr);
        if (tbl[i].we) chk($sformatf("tbl[%0d] mem_wdata", i), mem_if.mem_wdata, 32'hCAFE_0001);
      end
      if (tbl[i].push) chk($sformatf("tbl[%0d] fill_data", i), fill_data, 32'h5EED_0042);
    end

    // Full stack: push stalls until the pending spill completes.
    rst2();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 2'b01, 1'b0);
      chk("full stall", 32'(stall), 32'd1);
      chk("full count", 32'(count), 32'd16);
      chk("full mem_req", 32'(mem_if.mem_req), 32'd1);
    end
    cyc(1'b0, 1'b1, 2'b01, 1'b1);
    chk("full ack stall", 32'(stall), 32'd1);
    chk("full ack pop", 32'(bottom_pop), 32'd1);
    cyc(1'b0, 1'b1, 2'b01, 1'b0);
    chk("full accept stall", 32'(stall), 32'd0);
    chk("full accept count", 32'(count), 32'd15);
    chk("full accept mem_req", 32'(mem_if.mem_req), 32'd0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    chk("respill count", 32'(count), 32'd16);
    chk("respill mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("respill mem_addr", mem_if.mem_addr, 32'd1);

    // Drain under a pending spill, start a fill, then reset it mid-transaction.
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 2'b11, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b1);
    chk("drain pop", 32'(bottom_pop), 32'd1);
    chk("drain count", 32'(count), 32'd4);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    chk("gap count", 32'(count), 32'd3);
    chk("gap mem_req", 32'(mem_if.mem_req), 32'd0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    chk("fill mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("fill mem_we", 32'(mem_if.mem_we), 32'd0);
    chk("fill mem_addr", mem_if.mem_addr, 32'd1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    chk("rst-fill mem_req held", 32'(mem_if.mem_req), 32'd1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1);
    chk("rst-fill mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("late ack push", 32'(bottom_push), 32'd0);
    chk("rst-fill count", 32'(count), 32'd0);
    cyc(1'b0, 1'b1, 2'b10, 1'b0);
    chk("rst-fill ptr stall", 32'(stall), 32'd0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    chk("rst-fill underflow", 32'(underflow), 32'd1);
    chk("rst-fill idle", 32'(mem_if.mem_req), 32'd0);

    // Random traffic in episodes of differing push bias, each starting from reset.
    for (int e = 0; e < 4; e++) begin
      int bias;
      bias = (e == 0) ? 60 : (e == 1) ? 45 : (e == 2) ? 52 : 70;
      rst2();
      model_clear();
      for (int n = 0; n < 500; n++) rand_cycle(bias);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dstack_spill_control.md
# dstack_spill_control

Sequencer for the data-stack's on-chip storage: tracks the live on-chip depth from the per-instruction stack movement and spills the bottom entry to memory when the stack runs high. It refills the bottom entry from memory when the stack runs low, and stalls the core when a movement cannot be honoured yet. Sits between the data-stack control decode (movement) and the data-stack register file, with a single-outstanding memory port.

## Interface
- WORD_WIDTH, 32, data and address word width
- DEPTH, 16, on-chip stack entries
- SPILL_HIGH, 12, on-chip count at or above which a spill starts
- FILL_LOW, 4, on-chip count at or below which a fill starts (if spilled entries exist)
- STACK_BASE, 0, word address of the first spilled entry

Ports:
- clk  in  1  clock; the block uses one clock
- reset  in  1  synchronous, active-high reset
- movement  in  2  00 hold, 01 push one, 10 pop one, 11 pop two
- move_valid  in  1  movement is applied this cycle unless stall
- stall  out  1  core must hold the instruction; movement not applied
- underflow  out  1  sticky; pop requested with too few entries and nothing spilled
- count  out  $clog2(DEPTH+1)  live on-chip entries
- bottom_pop  out  1  register file drops its bottom entry at this edge
- bottom_push  out  1  register file inserts fill_data below its bottom at this edge
- fill_data  out  WORD_WIDTH  word to insert on bottom_push (= mem_rdata)
- bottom_data  in  WORD_WIDTH  current bottom on-chip entry
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 write (spill), 0 read (fill)
- mem_addr  out  WORD_WIDTH  word address
- mem_wdata  out  WORD_WIDTH  spill data (= bottom_data)
- mem_ack  in  1  transaction completes at this edge when mem_req=1
- mem_rdata  in  WORD_WIDTH  fill data, valid with mem_ack

## Operation
- Registers: count, spill_ptr (next free memory word, starts at STACK_BASE), state, underflow.
- spilled = spill_ptr − STACK_BASE (zero when spill_ptr == STACK_BASE).
- FSM states: IDLE, SPILL, FILL.
  - IDLE → SPILL when count ≥ SPILL_HIGH.
  - Otherwise, IDLE → FILL when count ≤ FILL_LOW and spilled > 0.
  - SPILL → IDLE on mem_ack; completes the write at spill_ptr, then spill_ptr += 1.
  - FILL → IDLE on mem_ack; completes the read at spill_ptr − 1, then spill_ptr −= 1.
- Outputs by state:
  - mem_req = 1 in SPILL and FILL.
  - mem_we = 1 in SPILL.
  - mem_addr = spill_ptr in SPILL, spill_ptr − 1 in FILL.
  - bottom_pop = SPILL & mem_ack.
  - bottom_push = FILL & mem_ack.
- Demand: need = 0, 1 or 2 pops for movement 00/01, 10, 11. grow = 1 for 01.
- stall conditions (move_valid only, registered count):
  - count == DEPTH and grow=1, or
  - count < need and spilled > 0.
- Underflow: count < need and spilled == 0 → underflow set (sticky until reset), no stall. Movement is applied with count clamped at 0.
- count_next = count + (applied push) − (applied pops) − bottom_pop + bottom_push. All terms apply in the same edge.
- Spill/fill decisions use registered count only; a FILL never starts while in SPILL, and vice versa. Exactly one memory transaction is outstanding at a time.
- spill_ptr wraps modulo 2^WORD_WIDTH; no overflow check on memory.

## Timing
- Reset values: count=0, spill_ptr=STACK_BASE, state=IDLE, underflow=0. All mem_* outputs, bottom_pop, bottom_push and stall are 0. fill_data follows mem_rdata.
- Reset mid-transaction: state returns to IDLE and mem_req drops on the next cycle. The transaction is abandoned and any later mem_ack is ignored.
- Start latency: the edge at which count becomes ≥ SPILL_HIGH is followed by one cycle in IDLE. mem_req rises at the next edge.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the mem_ack edge.
  - mem_ack in the first mem_req cycle is legal (minimum 1-cycle transaction).
  - After completion, mem_req is low for at least one cycle (IDLE).
- bottom_data is read live in SPILL. The register file must keep its bottom entry stable while in SPILL, except through bottom_pop.
- stall is combinational from registered count, spilled, movement and move_valid. Zero-cycle response.

## Test plan
- Reset: assert reset 2 cycles → count=0, mem_req=0, underflow=0, spill_ptr=0.
- Spill: 12 pushes, mem_ack delayed 3 cycles → mem_req=1, mem_we=1, mem_addr=0, mem_wdata=bottom_data. bottom_pop at ack, then count=11 and spill_ptr=1.
- Concurrent ack and movement:
  - Push on the spill-ack edge → count unchanged (12→12).
  - Pop-two on a fill-ack edge with count=4 → count=3.
- Full and empty:
  - count=16, push → stall=1 until a spill completes, then the push is accepted.
  - With 2 entries spilled, count=1, pop-two → stall until the fill brings count to 2.
- Underflow: count=1, nothing spilled, pop-two → underflow=1 (sticky), count=0, stall=0.
- Reset mid-FILL while mem_ack is pending → mem_req=0 next cycle, spill_ptr=STACK_BASE. A late mem_ack produces no bottom_push.
